// File: rtl/sm_display_pkg.sv
// Shared types and active-low gfedcba segment codes for the sign-magnitude sum display.
package sm_display_pkg;

  typedef logic [3:0] glyph_t;

  localparam glyph_t GLYPH_MINUS = 4'hA;
  localparam glyph_t GLYPH_BLANK = 4'hF;

  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };
  localparam logic [6:0] SEG_MINUS = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {DIG0, DIG1, DIG2, DIG3} digit_state_t;

endpackage

// File: rtl/seg7_decoder.sv
// Combinational glyph-to-segment decoder; unknown codes render as blank.
module seg7_decoder
  import sm_display_pkg::*;
(
  input  glyph_t     glyph_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    if (glyph_i <= 4'd9) begin
      seg_o = SEG_DIGIT[glyph_i];
    end else if (glyph_i == GLYPH_MINUS) begin
      seg_o = SEG_MINUS;
    end
  end

endmodule

// File: rtl/sm_sum_display_driver.sv
// Captures sign-magnitude sums and scans them onto a 4-digit active-low 7-segment display,
// swapping in new values only at frame boundaries.
module sm_sum_display_driver
  import sm_display_pkg::*;
#(
  parameter int unsigned REFRESH_CYCLES = 100000,
  parameter int unsigned BLANK_CYCLES   = 1000
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [4:0] sum_i,
  input  logic       sum_valid_i,
  output logic [3:0] an_o,
  output logic [6:0] seg_o,
  output logic       dp_o
);

  localparam int unsigned CntW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast  = CntW'(REFRESH_CYCLES - 1);
  localparam logic [CntW-1:0] CntBlank = CntW'(BLANK_CYCLES);

  logic [4:0]    pending_q, disp_q;
  digit_state_t  state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q;

  logic          frame_load;
  logic [3:0]    mag, units;
  logic          tens, neg, lit;
  glyph_t        glyph;
  logic [6:0]    seg_dec;

  assign frame_load = (state_q == DIG0) && (cnt_q == '0);

  // A valid on the load cycle lands in pending after the display has already sampled it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pending_q <= 5'b00000;
      disp_q    <= 5'b00000;
    end else begin
      if (sum_valid_i) pending_q <= sum_i;
      if (frame_load)  disp_q    <= pending_q;
    end
  end

  assign mag   = disp_q[3:0];
  assign tens  = (mag >= 4'd10);
  assign units = tens ? (mag - 4'd10) : mag;
  assign neg   = disp_q[4] & (mag != 4'd0);

  // Scan FSM: state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= DIG0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Scan FSM: next state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    if (cnt_q == CntLast) begin
      cnt_d = '0;
      unique case (state_q)
        DIG0:    state_d = DIG1;
        DIG1:    state_d = DIG2;
        DIG2:    state_d = DIG3;
        default: state_d = DIG0;
      endcase
    end
  end

  // Scan FSM: outputs
  assign lit = (cnt_q >= CntBlank);

  always_comb begin
    an_d  = 4'b1111;
    glyph = GLYPH_BLANK;
    unique case (state_q)
      DIG0: begin
        an_d  = 4'b1110;
        glyph = units;
      end
      DIG1: begin
        an_d  = 4'b1101;
        glyph = tens ? 4'd1 : GLYPH_BLANK;
      end
      DIG2: begin
        an_d  = 4'b1011;
        glyph = neg ? GLYPH_MINUS : GLYPH_BLANK;
      end
      default: begin
        an_d  = 4'b0111;
        glyph = GLYPH_BLANK;
      end
    endcase
    if (!lit) an_d = 4'b1111;
    seg_d = lit ? seg_dec : SEG_BLANK;
  end

  seg7_decoder u_seg7_decoder (
    .glyph_i (glyph),
    .seg_o   (seg_dec)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      an_q  <= 4'b1111;
      seg_q <= SEG_BLANK;
      dp_q  <= 1'b1;
    end else begin
      an_q  <= an_d;
      seg_q <= seg_d;
      dp_q  <= 1'b1;
    end
  end

  assign an_o  = an_q;
  assign seg_o = seg_q;
  assign dp_o  = dp_q;

endmodule

// File: tb/tb_sm_sum_display_driver.sv
// Self-checking bench: table of sums with hand-derived segment codes, checked frame by frame.
module tb_sm_sum_display_driver;

  localparam int unsigned Refresh = 8;
  localparam int unsigned Blank   = 2;

  logic       clk = 1'b0;
  logic       rst_ni;
  logic [4:0] sum;
  logic       sum_valid;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [6:0] s0;
    logic [6:0] s1;
    logic [6:0] s2;
  } frame_t;

  typedef struct {
    logic [4:0] sum;
    logic [6:0] s0;
    logic [6:0] s1;
    logic [6:0] s2;
  } vec_t;

  frame_t exp_q[$];
  vec_t   tbl[12];

  sm_sum_display_driver #(
    .REFRESH_CYCLES (Refresh),
    .BLANK_CYCLES   (Blank)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .sum_i       (sum),
    .sum_valid_i (sum_valid),
    .an_o        (an),
    .seg_o       (seg),
    .dp_o        (dp)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cmp(input string name, input logic [6:0] act, input logic [6:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Wait for a fresh entry into the given anode pattern, bounded.
  task automatic wait_enter(input logic [3:0] pat, input string name);
    int n = 0;
    while (an === pat && n < 200) begin tick(); n++; end
    while (an !== pat && n < 200) begin tick(); n++; end
    if (an !== pat) begin
      checks++;
      errors++;
      $display("FAIL %s: timeout waiting for an=%b, got %b", name, pat, an);
    end
  endtask

  task automatic check_rest(input string name, input frame_t f);
    wait_enter(4'b1101, name);
    cmp({name, " dig1"}, seg, f.s1);
    wait_enter(4'b1011, name);
    cmp({name, " dig2"}, seg, f.s2);
    wait_enter(4'b0111, name);
    cmp({name, " dig3"}, seg, 7'h7F);
  endtask

  task automatic check_frame(input string name);
    frame_t f;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty, got an=%b expected a queued frame", name, an);
      return;
    end
    f = exp_q.pop_front();
    wait_enter(4'b1110, name);
    cmp({name, " dig0"}, seg, f.s0);
    check_rest(name, f);
  endtask

  task automatic pulse_at(input logic [3:0] pat, input logic [4:0] v);
    wait_enter(pat, "pulse");
    sum       = v;
    sum_valid = 1'b1;
    tick();
    sum_valid = 1'b0;
  endtask

  task automatic push(input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] s2);
    frame_t f;
    f.s0 = s0;
    f.s1 = s1;
    f.s2 = s2;
    exp_q.push_back(f);
  endtask

  initial begin
    int n;
    tbl[0]  = '{5'b01101, 7'h30, 7'h79, 7'h7F};  // +13
    tbl[1]  = '{5'b10110, 7'h02, 7'h7F, 7'h3F};  // -6
    tbl[2]  = '{5'b11110, 7'h19, 7'h79, 7'h3F};  // -14
    tbl[3]  = '{5'b10000, 7'h40, 7'h7F, 7'h7F};  // -0
    tbl[4]  = '{5'b01111, 7'h12, 7'h79, 7'h7F};  // +15
    tbl[5]  = '{5'b11010, 7'h40, 7'h79, 7'h3F};  // -10
    tbl[6]  = '{5'b10001, 7'h79, 7'h7F, 7'h3F};  // -1
    tbl[7]  = '{5'b01000, 7'h00, 7'h7F, 7'h7F};  // +8
    tbl[8]  = '{5'b00010, 7'h24, 7'h7F, 7'h7F};  // +2
    tbl[9]  = '{5'b10111, 7'h78, 7'h7F, 7'h3F};  // -7
    tbl[10] = '{5'b00101, 7'h12, 7'h7F, 7'h7F};  // +5
    tbl[11] = '{5'b11110, 7'h19, 7'h79, 7'h3F};  // -14

    rst_ni    = 1'b0;
    sum       = '0;
    sum_valid = 1'b0;

    // Reset
    repeat (5) tick();
    cmp("reset an", {3'b0, an}, 7'h0F);
    cmp("reset seg", seg, 7'h7F);
    cmp("reset dp", {6'b0, dp}, 7'h01);
    @(negedge clk);
    rst_ni = 1'b1;
    n = 0;
    do begin tick(); n++; end while (an !== 4'b1110 && n < 50);
    cmp("first lit delay", 7'(n), 7'(Blank + 1));
    cmp("first lit dig0", seg, 7'h40);
    cmp("first lit dp", {6'b0, dp}, 7'h01);
    begin
      frame_t z;
      z.s0 = 7'h40; z.s1 = 7'h7F; z.s2 = 7'h7F;
      check_rest("reset frame", z);
    end

    // Table: pulse during DIG1 so the very next frame must show it
    for (int i = 0; i < 12; i++) begin
      pulse_at(4'b1101, tbl[i].sum);
      push(tbl[i].s0, tbl[i].s1, tbl[i].s2);
      check_frame($sformatf("vec%0d", i));
    end

    // Tearing: +9 arrives mid-frame, rest of frame keeps -14
    pulse_at(4'b1101, 5'b01001);
    cmp("tear dig1 an", {3'b0, an}, 7'h0D);
    cmp("tear dig1 old", seg, 7'h79);
    wait_enter(4'b1011, "tear");
    cmp("tear dig2 old", seg, 7'h3F);
    push(7'h10, 7'h7F, 7'h7F);
    check_frame("tear new");

    // Collision: valid on the DIG0 load cycle shows one frame later
    wait_enter(4'b0111, "coll");
    repeat (Refresh - Blank - 1) tick();
    cmp("coll last dig3", {3'b0, an}, 7'h07);
    sum       = 5'b00110;
    sum_valid = 1'b1;
    tick();
    sum_valid = 1'b0;
    cmp("coll load blank", {3'b0, an}, 7'h0F);
    push(7'h10, 7'h7F, 7'h7F);
    push(7'h02, 7'h7F, 7'h7F);
    check_frame("coll old");
    check_frame("coll new");

    // Overwrite: +3 then +4 in one frame
    pulse_at(4'b1101, 5'b00011);
    pulse_at(4'b1011, 5'b00100);
    push(7'h19, 7'h7F, 7'h7F);
    check_frame("overwrite");

    // Async reset mid-scan, between edges
    wait_enter(4'b1011, "async");
    #2;
    rst_ni = 1'b0;
    #1;
    cmp("async an", {3'b0, an}, 7'h0F);
    cmp("async seg", seg, 7'h7F);
    exp_q.delete();
    repeat (3) tick();
    @(negedge clk);
    rst_ni = 1'b1;
    push(7'h40, 7'h7F, 7'h7F);
    check_frame("after async");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
